// File: rtl/rcl_pkg.sv
// rcl_pkg: shared constants, relation codes, host state and job types
// for the circle/line relation (RCL) serial protocol.
package rcl_pkg;

  localparam int COEF_W    = 5;
  localparam int NUM_BEATS = 3;

  localparam logic [1:0] REL_NONE    = 2'd0;
  localparam logic [1:0] REL_TANGENT = 2'd1;
  localparam logic [1:0] REL_CROSS   = 2'd2;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} host_state_t;

  // a,b,c: signed line coefficients; m,n: signed centre; k: unsigned r^2
  typedef struct packed {
    logic [COEF_W-1:0] a;
    logic [COEF_W-1:0] b;
    logic [COEF_W-1:0] c;
    logic [COEF_W-1:0] m;
    logic [COEF_W-1:0] n;
    logic [COEF_W-1:0] k;
  } rcl_job_t;

  // {coef_L, coef_Q} carried on beat 'sel' of a job
  function automatic logic [2*COEF_W-1:0] beat_data(rcl_job_t j, logic [1:0] sel);
    case (sel)
      2'd0:    beat_data = {j.a, j.m};
      2'd1:    beat_data = {j.b, j.n};
      default: beat_data = {j.c, j.k};
    endcase
  endfunction

endpackage

// File: rtl/rcl_host_if.sv
// rcl_host_if: request, RCL beat and response signals of the RCL host.
// master = the host itself, slave = the environment (requester, RCL, consumer).
interface rcl_host_if;
  import rcl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [COEF_W-1:0] req_a;
  logic [COEF_W-1:0] req_b;
  logic [COEF_W-1:0] req_c;
  logic [COEF_W-1:0] req_m;
  logic [COEF_W-1:0] req_n;
  logic [COEF_W-1:0] req_k;

  logic              in_valid;
  logic [COEF_W-1:0] coef_L;
  logic [COEF_W-1:0] coef_Q;
  logic              rcl_out_valid;
  logic [1:0]        rcl_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_code;
  logic              rsp_err;

  modport master (
    input  req_valid, req_a, req_b, req_c, req_m, req_n, req_k,
    output req_ready,
    output in_valid, coef_L, coef_Q,
    input  rcl_out_valid, rcl_out,
    output rsp_valid, rsp_code, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_a, req_b, req_c, req_m, req_n, req_k,
    input  req_ready,
    input  in_valid, coef_L, coef_Q,
    output rcl_out_valid, rcl_out,
    input  rsp_valid, rsp_code, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/rcl_host.sv
// rcl_host: accepts one job, sends it to the RCL as three back-to-back
// beats, waits for the relation code and returns it on the response port.
// Optional macro RCL_HOST_TIMEOUT_EN bounds the WAIT state by TIMEOUT cycles
// and reports an abort through rsp_err.
module rcl_host
  import rcl_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rcl_host_if.master bus
);

  host_state_t state, state_nxt;
  logic [1:0]  beat;
  rcl_job_t    job;
  logic        last_beat;
  logic        tmo_hit;

  if (TIMEOUT < 3 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rcl_host: TIMEOUT must be within 3..255");
  end

  assign last_beat     = (beat == 2'(NUM_BEATS - 1));
  assign bus.req_ready = (state == IDLE);

`ifdef RCL_HOST_TIMEOUT_EN
  logic [7:0] timer;
  logic       rsp_err_q;

  assign tmo_hit     = (timer == 8'(TIMEOUT - 1));
  assign bus.rsp_err = rsp_err_q;

  // WAIT-cycle counter; held at 0 while sending so WAIT always starts fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              timer <= '0;
    else if (state == SEND)  timer <= '0;
    else if (state == WAIT)  timer <= timer + 8'd1;
  end

  // abort flag: a real result on the expiry cycle takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rsp_err_q <= 1'b0;
    else if (state == WAIT) begin
      if (bus.rcl_out_valid) rsp_err_q <= 1'b0;
      else if (tmo_hit)      rsp_err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.req_valid)                    state_nxt = SEND;
      SEND: if (last_beat)                        state_nxt = WAIT;
      WAIT: if (bus.rcl_out_valid || tmo_hit)     state_nxt = RESP;
      RESP: if (bus.rsp_ready)                    state_nxt = IDLE;
      default:                                    state_nxt = IDLE;
    endcase
  end

  // job latch, registered beat outputs and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat          <= '0;
      job           <= '0;
      bus.in_valid  <= 1'b0;
      bus.coef_L    <= '0;
      bus.coef_Q    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_code  <= REL_NONE;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          // beat 0 goes out straight from the request so it appears at T+1
          job          <= '{a: bus.req_a, b: bus.req_b, c: bus.req_c,
                            m: bus.req_m, n: bus.req_n, k: bus.req_k};
          beat         <= '0;
          bus.in_valid <= 1'b1;
          bus.coef_L   <= bus.req_a;
          bus.coef_Q   <= bus.req_m;
        end
        SEND: if (last_beat) begin
          bus.in_valid <= 1'b0;
          bus.coef_L   <= '0;
          bus.coef_Q   <= '0;
        end else begin
          beat                     <= beat + 2'd1;
          {bus.coef_L, bus.coef_Q} <= beat_data(job, beat + 2'd1);
        end
        WAIT: if (bus.rcl_out_valid) begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_code  <= bus.rcl_out;
        end else if (tmo_hit) begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_code  <= REL_NONE;
        end
        RESP: if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rcl_host.sv
// tb_rcl_host: directed bench for rcl_host with a behavioural RCL stub that
// answers in the 3rd WAIT cycle. Define RCL_HOST_TIMEOUT_EN to cover the timeout.
module tb_rcl_host;
  import rcl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic       stub_en = 1'b1;
  logic       stub_vld = 1'b0;
  logic [1:0] stub_code = 2'd0;
  logic       inj_vld = 1'b0;
  logic [1:0] inj_code = 2'd0;

  rcl_host_if bus();

  rcl_host #(.TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.rcl_out_valid = stub_vld | inj_vld;
  assign bus.rcl_out       = inj_vld ? inj_code : stub_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RCL stub: collects three beats, decides the relation, answers 3 cycles later
  initial begin : rcl_stub
    int nb, sa, sb, sc, sm, sn, sk, p, lhs, rhs;
    nb = 0; sa = 0; sb = 0; sc = 0; sm = 0; sn = 0; sk = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) nb = 0;
      else if (bus.in_valid) begin
        case (nb)
          0:       begin sa = int'($signed(bus.coef_L)); sm = int'($signed(bus.coef_Q)); end
          1:       begin sb = int'($signed(bus.coef_L)); sn = int'($signed(bus.coef_Q)); end
          default: begin sc = int'($signed(bus.coef_L)); sk = int'(bus.coef_Q); end
        endcase
        nb++;
        if (nb == 3) begin
          nb = 0;
          if (stub_en) begin
            p   = sa * sm + sb * sn + sc;
            lhs = p * p;
            rhs = sk * (sa * sa + sb * sb);
            stub_code = (lhs < rhs) ? REL_CROSS : (lhs == rhs) ? REL_TANGENT : REL_NONE;
            repeat (3) @(negedge clk);
            stub_vld = 1'b1;
            @(negedge clk);
            stub_vld = 1'b0;
          end
        end
      end
    end
  end

  // call at a negedge while idle; returns #1 after acceptance edge T
  task automatic start_job(input logic [4:0] a, b, c, m, n, k);
    bus.req_a = a; bus.req_b = b; bus.req_c = c;
    bus.req_m = m; bus.req_n = n; bus.req_k = k;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // full job with beat and latency checks; returns at the negedge of T+7
  task automatic run_job(input string tag, input logic [4:0] a, b, c, m, n, k,
                         input logic [1:0] code);
    logic [4:0] el[3];
    logic [4:0] eq[3];
    el = '{a, b, c};
    eq = '{m, n, k};
    start_job(a, b, c, m, n, k);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("%s/in_valid%0d", tag, i), 32'(bus.in_valid), 32'd1);
      chk($sformatf("%s/coef_L%0d", tag, i), 32'(bus.coef_L), 32'(el[i]));
      chk($sformatf("%s/coef_Q%0d", tag, i), 32'(bus.coef_Q), 32'(eq[i]));
    end
    @(negedge clk);
    chk({tag, "/in_valid_off"}, 32'(bus.in_valid), 32'd0);
    chk({tag, "/coef_clr"}, 32'({bus.coef_L, bus.coef_Q}), 32'd0);
    repeat (2) @(negedge clk);
    chk({tag, "/rsp_early"}, 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "/rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "/rsp_code"}, 32'(bus.rsp_code), 32'(code));
    chk({tag, "/rsp_err"}, 32'(bus.rsp_err), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rise[$];
    int nrsp, code_or, seen;
    logic prev_iv;

    bus.req_valid = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.req_c = '0;
    bus.req_m = '0; bus.req_n = '0; bus.req_k = '0;
    bus.rsp_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst/req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst/in_valid", 32'(bus.in_valid), 32'd0);
    chk("rst/coef", 32'({bus.coef_L, bus.coef_Q}), 32'd0);
    chk("rst/rsp", 32'({bus.rsp_valid, bus.rsp_code, bus.rsp_err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // intersect, tangent
    run_job("cross", 5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h04, REL_CROSS);
    @(negedge clk);
    chk("cross/rsp_done", 32'(bus.rsp_valid), 32'd0);
    chk("cross/idle", 32'(bus.req_ready), 32'd1);
    run_job("tangent", 5'h01, 5'h00, 5'h1E, 5'h00, 5'h00, 5'h04, REL_TANGENT);
    @(negedge clk);

    // rcl_out_valid while idle must not produce a response
    inj_code = REL_CROSS;
    inj_vld  = 1'b1;
    @(negedge clk);
    inj_vld  = 1'b0;
    @(negedge clk);
    chk("idle_out_valid/rsp", 32'(bus.rsp_valid), 32'd0);
    chk("idle_out_valid/ready", 32'(bus.req_ready), 32'd1);

    // back-to-back no-intersection jobs, req_valid held high
    bus.req_a = 5'h01; bus.req_b = 5'h00; bus.req_c = 5'h1D;
    bus.req_m = 5'h00; bus.req_n = 5'h00; bus.req_k = 5'h04;
    bus.req_valid = 1'b1;
    prev_iv = 1'b0; nrsp = 0; code_or = 0;
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      if (bus.in_valid && !prev_iv) rise.push_back(t);
      prev_iv = bus.in_valid;
      if (bus.rsp_valid) begin nrsp++; code_or |= int'(bus.rsp_code); end
      if (t == 16) bus.req_valid = 1'b0;
    end
    chk("b2b/jobs", 32'(rise.size()), 32'd2);
    if (rise.size() >= 2) chk("b2b/period", 32'(rise[1] - rise[0]), 32'd8);
    chk("b2b/responses", 32'(nrsp), 32'd2);
    chk("b2b/code", 32'(code_or), 32'd0);
    @(negedge clk);
    chk("b2b/idle", 32'({bus.req_ready, bus.in_valid}), 32'b10);

    // backpressure: response held, stray request ignored
    bus.rsp_ready = 1'b0;
    run_job("bp", 5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h04, REL_CROSS);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp/hold_valid%0d", i), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp/hold_code%0d", i), 32'(bus.rsp_code), 32'(REL_CROSS));
      chk($sformatf("bp/req_ready%0d", i), 32'(bus.req_ready), 32'd0);
      if (i == 1) begin bus.req_a = 5'h07; bus.req_valid = 1'b1; end
      if (i == 2) bus.req_valid = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp/released", 32'({bus.rsp_valid, bus.req_ready, bus.in_valid}), 32'b010);
    run_job("bp_next", 5'h01, 5'h00, 5'h1E, 5'h00, 5'h00, 5'h04, REL_TANGENT);
    @(negedge clk);

    // reset during beat 1
    start_job(5'h00, 5'h01, 5'h00, 5'h00, 5'h03, 5'h04);
    repeat (2) @(negedge clk);
    chk("mid_rst/beat1", 32'({bus.in_valid, bus.coef_L, bus.coef_Q}), 32'({1'b1, 5'h01, 5'h03}));
    rst_n = 1'b0;
    #1;
    chk("mid_rst/outputs", 32'({bus.in_valid, bus.coef_L, bus.coef_Q}), 32'd0);
    chk("mid_rst/req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst/after", 32'({bus.req_ready, bus.rsp_valid}), 32'b10);
    run_job("post_rst", 5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h04, REL_CROSS);
    @(negedge clk);

    // silent RCL
    stub_en = 1'b0;
`ifdef RCL_HOST_TIMEOUT_EN
    start_job(5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h04);
    repeat (11) @(negedge clk);
    chk("tmo/early", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("tmo/rsp", 32'({bus.rsp_valid, bus.rsp_code, bus.rsp_err}), 32'b1001);
    @(negedge clk);
    chk("tmo/idle", 32'(bus.req_ready), 32'd1);
    // result arriving on the expiry cycle wins
    start_job(5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h04);
    repeat (11) @(negedge clk);
    inj_code = REL_TANGENT;
    inj_vld  = 1'b1;
    @(negedge clk);
    inj_vld  = 1'b0;
    chk("tmo_tie/rsp", 32'({bus.rsp_valid, bus.rsp_code, bus.rsp_err}), 32'b1010);
    @(negedge clk);
`else
    start_job(5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h04);
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("no_tmo/rsp_seen", 32'(seen), 32'd0);
    chk("no_tmo/waiting", 32'({bus.req_ready, bus.in_valid, bus.rsp_err}), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
`endif
    stub_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rcl_host.md
Name: rcl_host

Overview:
- Initiator side of the circle/line relation (RCL) serial protocol.
- Accepts one parallel job (line coefficients a,b,c; circle centre m,n; squared radius k) on a valid/ready request port.
- Serialises the job as three beats on coef_L/coef_Q with in_valid, then waits for the RCL's out_valid/out.
- Returns the 2-bit relation code on a valid/ready response port. One job is outstanding at a time.

Parameters:
- TIMEOUT, 8: maximum WAIT cycles before abort. Legal range 3..255. Used only when RCL_HOST_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  job request valid
- req_ready  out  1  host can accept a job (high exactly in IDLE)
- req_a, req_b, req_c  in  5 each  signed line coefficients
- req_m, req_n  in  5 each  signed circle centre
- req_k  in  5  unsigned squared radius
- in_valid  out  1  beat valid toward RCL (registered)
- coef_L  out  5  beat data: a, b, c (registered)
- coef_Q  out  5  beat data: m, n, k (registered)
- rcl_out_valid  in  1  RCL result valid
- rcl_out  in  2  RCL relation: 0 none, 1 tangent, 2 intersect
- rsp_valid  out  1  response valid (registered)
- rsp_ready  in  1  response consumer ready
- rsp_code  out  2  captured relation code
- rsp_err  out  1  timeout abort flag (constant 0 without the macro)

Behaviour:
- Reset (async, immediate):
  - state IDLE; beat counter and timer 0.
  - in_valid, coef_L, coef_Q, rsp_valid, rsp_code, rsp_err all 0.
  - req_ready 1.
  - Reset mid-job aborts the job silently; the RCL shares rst_n.
- IDLE:
  - req_ready=1.
  - On req_valid at edge T: latch all six fields, go to SEND with beat=0.
  - Latched fields do not change until the next IDLE acceptance.
- SEND: in_valid=1 during cycles T+1, T+2, T+3.
  - Beat 0: coef_L=a, coef_Q=m.
  - Beat 1: coef_L=b, coef_Q=n.
  - Beat 2: coef_L=c, coef_Q=k.
  - Beats are strictly back-to-back; no stalls.
  - After beat 2: in_valid=0, coef_L/coef_Q=0, go to WAIT at T+4.
- WAIT:
  - in_valid stays 0.
  - On rcl_out_valid: capture rcl_out into rsp_code, rsp_err=0, go to RESP.
  - Nominal RCL response arrives in the 3rd WAIT cycle (T+6), so rsp_valid rises at T+7.
- RESP:
  - rsp_valid=1; rsp_code and rsp_err held stable until rsp_ready.
  - Handshake at edge R: rsp_valid=0 and state IDLE at R+1.
  - Minimum job period with rsp_ready tied high: 8 cycles.
- Ignored inputs:
  - req_valid outside IDLE is ignored; req_ready=0.
  - rcl_out_valid outside WAIT is ignored.
- Arithmetic: none. Fields pass through bit-exact; sign handling belongs to the RCL.

Optional Feature:
- RCL_HOST_TIMEOUT_EN defined:
  - An 8-bit timer clears on entry to WAIT and increments each WAIT cycle.
  - If TIMEOUT WAIT cycles pass without rcl_out_valid, go to RESP with rsp_code=0, rsp_err=1.
  - rcl_out_valid in the same cycle as expiry: the valid result wins, rsp_err=0.
- Not defined: no timer logic; WAIT is unbounded; rsp_err tied 0.

Decomposition:
- Package rcl_pkg holds:
  - COEF_W=5, NUM_BEATS=3.
  - Relation codes REL_NONE=0, REL_TANGENT=1, REL_CROSS=2.
  - Host state enum: IDLE, SEND, WAIT, RESP.
- No sub-module: a single FSM with beat counter and optional timer.

Test Plan:
- Intersect, RCL instance in the loop: a=1, b=0, c=0, m=0, n=0, k=4 → coef_L 01,00,00 and coef_Q 00,00,04 on T+1..T+3; rsp_valid at T+7 with code 2.
- Tangent: a=1, b=0, c=-2 (5'h1E), m=n=0, k=4 → coef_L beats 01,00,1E; code 1, rsp_err 0.
- No intersection: a=1, b=0, c=-3, k=4 → code 0; back-to-back jobs with rsp_ready=1 are accepted every 8 cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_code stable; req_ready=0; a req_valid pulse is ignored; job accepted after the handshake.
- Timeout (macro on, TIMEOUT=8, RCL stubbed silent) → rsp_valid with rsp_err=1, code 0 after 8 WAIT cycles. Same stub with the macro off → stays in WAIT for 100 cycles.
- Assert rst_n low during beat 1 → in_valid, coef_L, coef_Q drop to 0 immediately; after release req_ready=1 and the next job completes normally.
